mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the address width.
REQ-003 Parameter DEPTH, default 128, SHALL set the number of valid memory words.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 mN_req  input  1  (N=0,1) SHALL be the request, held high until mN_gnt is seen.
REQ-007 mN_we  input  1  SHALL select write (1) or read (0).
REQ-008 mN_addr  input  ADDR_WIDTH  SHALL be the word address.
REQ-009 mN_wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-010 mN_gnt  output  1  SHALL be a one-cycle acceptance pulse.
REQ-011 mN_rvalid  output  1  SHALL be a one-cycle read-data-valid pulse.
REQ-012 mN_rdata  output  DATA_WIDTH  SHALL be the read data, meaningful only with mN_rvalid.
REQ-013 mN_err  output  1  SHALL flag an out-of-range address; it pulses with mN_gnt.
REQ-014 mem_WE  output  1  SHALL be the memory write enable.
REQ-015 mem_write_address, mem_read_address  output  ADDR_WIDTH  SHALL be the memory addresses.
REQ-016 mem_write_data  output  DATA_WIDTH  SHALL be the memory write data.
REQ-017 mem_read_data  input  DATA_WIDTH  SHALL be the memory read data, registered by the memory one edge after the address is sampled.

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and RDATA.
REQ-019 In IDLE with any request active, the arbiter SHALL pick one requester, latch its we/addr/wdata into the memory-side registers, and go to ISSUE on the next edge.
REQ-020 Arbitration SHALL be round-robin: on a conflict, the master not granted last wins; after reset, m0 wins.
REQ-021 In ISSUE, the winner's gnt SHALL be high for exactly one cycle, and the memory-side outputs SHALL hold the latched command.
REQ-022 mem_WE SHALL be high only in ISSUE, only for an in-range write; it SHALL be 0 in every other state.
REQ-023 From ISSUE, a write (or any errored command) SHALL go to IDLE, and an in-range read SHALL go to RDATA.
REQ-024 In RDATA, the winner's rvalid SHALL be high for one cycle with rdata = mem_read_data; the FSM then goes to IDLE.
REQ-025 Read latency SHALL be: req sampled in IDLE cycle k, gnt in k+1, rvalid in k+2; one transaction at a time.
REQ-026 Write timing SHALL be: gnt in k+1, and the memory is updated at the end of k+1, so a read granted afterwards returns the new data.
REQ-027 An address >= DEPTH SHALL raise err with gnt and SHALL NOT write; for such a read, no rvalid is issued.
REQ-028 Requests SHALL be ignored in ISSUE and RDATA.
REQ-029 A master whose req is still high in IDLE after its gnt SHALL be treated as a new request.
REQ-030 Only the winner's rdata SHALL be driven; the other master's rdata SHALL be 0.
REQ-031 The upper address bits SHALL pass unmodified to the memory ports.

Reset
REQ-032 rst SHALL force state IDLE, all gnt/rvalid/err = 0, mem_WE = 0, addresses/data = 0, and the round-robin pointer to favour m0.
REQ-033 A reset in ISSUE SHALL suppress the pending write edge only if sampled on that same edge; a pending rvalid SHALL be dropped.

Structure
REQ-034 A package mem_arb_pkg SHALL hold the state enumeration and the DATA_WIDTH, ADDR_WIDTH and DEPTH defaults.
REQ-035 The two-way round-robin selection SHALL be the sub-module rr_arb2 (inputs req[1:0] and last-grant pointer; output one-hot grant).

Verification
REQ-036 m0 write addr 5 data 0xA5A5_0001, then m0 read addr 5 -> m0_gnt at k+1, m0_rvalid at k+2 with 0xA5A5_0001.
REQ-037 m0 and m1 both request continuously after reset -> grants alternate m0, m1, m0, m1; no rvalid goes to the wrong master.
REQ-038 m1 write addr 127 data 0x1234 -> mem_WE=1 for one cycle; a later read of addr 127 returns 0x1234.
REQ-039 m0 write addr 128 data 0xFFFF -> m0_err and m0_gnt pulse, mem_WE stays 0; a read of addr 128 gives err and no rvalid.
REQ-040 rst asserted in the ISSUE cycle of a read -> no rvalid; next request is granted to m0 with 2-cycle read latency.
REQ-041 m1 write addr 9 then m0 read addr 9 queued simultaneously -> write completes first and the read returns the new value.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
// Holds the FSM state encoding, the parameter defaults and an address range check.
package mem_arb_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam int          ADDR_WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF      = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    // Addresses are widened so that any ADDR_WIDTH up to 64 compares correctly against depth.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
        return addr < 64'(depth);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the memory.
// The master modport is the outside world; the slave modport is the arbiter's view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_err;

    logic                  mem_WE;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_WE, mem_write_address, mem_read_address, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_WE, mem_write_address, mem_read_address, mem_write_data,
        input  mem_read_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a conflict the master not granted last wins.
// last_gnt = 1 means m1 was granted last, so m0 is favoured.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one synchronous single-port-style memory, one transaction at a time.
// Each command takes IDLE -> ISSUE (grant) and, for in-range reads, -> RDATA (read data returned).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arb_state_t            state_reg, state_next;
    logic                  last_reg, last_next;
    logic                  win_reg, win_next;
    logic                  we_reg, we_next;
    logic                  err_reg, err_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;

    logic [1:0]            req_vec;
    logic [1:0]            grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [1:0]            gnt_vec;
    logic [1:0]            err_vec;
    logic [1:0]            rvalid_vec;
    logic [DATA_WIDTH-1:0] rdata_arr [2];

    assign req_vec = {bus.m1_req, bus.m0_req};

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .last_gnt (last_reg),
        .grant    (grant)
    );

    assign sel_we    = grant[1] ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = grant[1] ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = grant[1] ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            win_reg   <= 1'b0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            win_reg   <= win_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        win_next   = win_reg;
        we_next    = we_reg;
        err_next   = err_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    win_next   = grant[1] & ~grant[0];
                    last_next  = grant[1] & ~grant[0];
                    we_next    = sel_we;
                    addr_next  = sel_addr;
                    wdata_next = sel_wdata;
                    err_next   = ~addr_in_range(64'(sel_addr), DEPTH);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = (!we_reg && !err_reg) ? RDATA : IDLE;
            end
            RDATA: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]    = (state_reg == ISSUE) && (win_reg == 1'(gi));
        assign err_vec[gi]    = gnt_vec[gi] && err_reg;
        assign rvalid_vec[gi] = (state_reg == RDATA) && (win_reg == 1'(gi));
        assign rdata_arr[gi]  = rvalid_vec[gi] ? bus.mem_read_data : '0;
    end

    assign bus.m0_gnt    = gnt_vec[0];
    assign bus.m1_gnt    = gnt_vec[1];
    assign bus.m0_err    = err_vec[0];
    assign bus.m1_err    = err_vec[1];
    assign bus.m0_rvalid = rvalid_vec[0];
    assign bus.m1_rvalid = rvalid_vec[1];
    assign bus.m0_rdata  = rdata_arr[0];
    assign bus.m1_rdata  = rdata_arr[1];

    // Gating with rst lets a reset sampled on the write edge cancel that write.
    assign bus.mem_WE            = (state_reg == ISSUE) && we_reg && !err_reg && !rst;
    assign bus.mem_write_address = addr_reg;
    assign bus.mem_read_address  = addr_reg;
    assign bus.mem_write_data    = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model on the memory side.
// Inputs are driven and outputs sampled 1 time unit after each falling clock edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:255];

    always @(posedge clk) begin
        if (bus.mem_WE) mem[bus.mem_write_address[7:0]] <= bus.mem_write_data;
        bus.mem_read_data <= mem[bus.mem_read_address[7:0]];
    end

    // {m0_gnt, m0_err, m0_rvalid, m1_gnt, m1_err, m1_rvalid, mem_WE}
    function automatic logic [6:0] status();
        return {bus.m0_gnt, bus.m0_err, bus.m0_rvalid,
                bus.m1_gnt, bus.m1_err, bus.m1_rvalid, bus.mem_WE};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (m == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL reset_flags got %b expected 0000000", status());
        end
        checks++;
        if ({bus.mem_write_address, bus.mem_read_address, bus.mem_write_data} !== '0) begin
            errors++; $display("FAIL reset_mem_bus got wa=%h ra=%h wd=%h expected all 0",
                               bus.mem_write_address, bus.mem_read_address, bus.mem_write_data);
        end
        checks++;
        if ({bus.m0_rdata, bus.m1_rdata} !== '0) begin
            errors++; $display("FAIL reset_rdata got %h %h expected 0 0", bus.m0_rdata, bus.m1_rdata);
        end
        rst = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 16'd5, 32'hA5A5_0001);
        tick();
        checks++;
        if (status() !== 7'b1000001 || bus.mem_write_address !== 16'd5 || bus.mem_write_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wr5_issue got st=%b wa=%h wd=%h expected 1000001 0005 a5a50001",
                               status(), bus.mem_write_address, bus.mem_write_data);
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL wr5_after got %b expected 0000000", status());
        end
        drive(0, 1'b0, 16'd5, '0);
        tick();
        checks++;
        if (status() !== 7'b1000000 || bus.mem_read_address !== 16'd5) begin
            errors++; $display("FAIL rd5_gnt got st=%b ra=%h expected 1000000 0005", status(), bus.mem_read_address);
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0010000 || bus.m0_rdata !== 32'hA5A5_0001 || bus.m1_rdata !== '0) begin
            errors++; $display("FAIL rd5_rvalid got st=%b d0=%h d1=%h expected 0010000 a5a50001 0",
                               status(), bus.m0_rdata, bus.m1_rdata);
        end
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL rd5_end got %b expected 0000000", status());
        end
        $display("txn m0 write/read addr 5");
    endtask

    task automatic test_boundary_127();
        drive(1, 1'b1, 16'd127, 32'h0000_1234);
        tick();
        checks++;
        if (status() !== 7'b0001001 || bus.mem_write_address !== 16'd127) begin
            errors++; $display("FAIL wr127_issue got st=%b wa=%h expected 0001001 007f", status(), bus.mem_write_address);
        end
        drop(1);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL wr127_we_once got %b expected 0000000", status());
        end
        drive(1, 1'b0, 16'd127, '0);
        tick();
        checks++;
        if (status() !== 7'b0001000) begin
            errors++; $display("FAIL rd127_gnt got %b expected 0001000", status());
        end
        drop(1);
        tick();
        checks++;
        if (status() !== 7'b0000010 || bus.m1_rdata !== 32'h0000_1234 || bus.m0_rdata !== '0) begin
            errors++; $display("FAIL rd127_rvalid got st=%b d1=%h d0=%h expected 0000010 00001234 0",
                               status(), bus.m1_rdata, bus.m0_rdata);
        end
        tick();
        $display("txn m1 write/read addr 127");
    endtask

    task automatic test_out_of_range();
        drive(0, 1'b1, 16'd128, 32'h0000_FFFF);
        tick();
        checks++;
        if (status() !== 7'b1100000) begin
            errors++; $display("FAIL wr128_err got %b expected 1100000", status());
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL wr128_after got %b expected 0000000", status());
        end
        drive(0, 1'b0, 16'd128, '0);
        tick();
        checks++;
        if (status() !== 7'b1100000) begin
            errors++; $display("FAIL rd128_err got %b expected 1100000", status());
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL rd128_no_rvalid got %b expected 0000000", status());
        end
        drive(1, 1'b0, 16'h8005, '0);
        tick();
        checks++;
        if (status() !== 7'b0001100 || bus.mem_read_address !== 16'h8005) begin
            errors++; $display("FAIL rd8005_upper got st=%b ra=%h expected 0001100 8005", status(), bus.mem_read_address);
        end
        drop(1);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL rd8005_no_rvalid got %b expected 0000000", status());
        end
        $display("txn out-of-range addr 128 and 0x8005");
    endtask

    task automatic test_round_robin();
        logic [6:0]    exp_st;
        logic [DW-1:0] exp_d;
        rst = 1'b1;
        drive(0, 1'b0, 16'd5, '0);
        drive(1, 1'b0, 16'd127, '0);
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (status() !== 7'b0000000) begin
                errors++; $display("FAIL rr_idle%0d got %b expected 0000000", t, status());
            end
            tick();
            exp_st = (t % 2 == 0) ? 7'b1000000 : 7'b0001000;
            checks++;
            if (status() !== exp_st) begin
                errors++; $display("FAIL rr_gnt%0d got %b expected %b", t, status(), exp_st);
            end
            tick();
            exp_st = (t % 2 == 0) ? 7'b0010000 : 7'b0000010;
            exp_d  = (t % 2 == 0) ? 32'hA5A5_0001 : 32'h0000_1234;
            checks++;
            if (status() !== exp_st || (bus.m0_rdata | bus.m1_rdata) !== exp_d
                || (t % 2 == 0 && bus.m1_rdata !== '0) || (t % 2 == 1 && bus.m0_rdata !== '0)) begin
                errors++; $display("FAIL rr_rvalid%0d got st=%b d0=%h d1=%h expected %b data %h",
                                   t, status(), bus.m0_rdata, bus.m1_rdata, exp_st, exp_d);
            end
            tick();
            $display("txn round-robin grant %0d to m%0d", t, t % 2);
        end
        drop(0);
        drop(1);
        tick();
    endtask

    task automatic test_reset_in_issue();
        drive(0, 1'b1, 16'd5, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (status() !== 7'b1000001) begin
            errors++; $display("FAIL rstwr_issue got %b expected 1000001", status());
        end
        rst = 1'b1;
        drop(0);
        #1;
        checks++;
        if (bus.mem_WE !== 1'b0) begin
            errors++; $display("FAIL rstwr_we_gated got %b expected 0", bus.mem_WE);
        end
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 16'd5, '0);
        tick();
        checks++;
        if (status() !== 7'b1000000) begin
            errors++; $display("FAIL rstrd_issue got %b expected 1000000", status());
        end
        rst = 1'b1;
        drop(0);
        tick();
        rst = 1'b0;
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL rstrd_no_rvalid got %b expected 0000000", status());
        end
        drive(0, 1'b0, 16'd5, '0);
        drive(1, 1'b0, 16'd127, '0);
        tick();
        checks++;
        if (status() !== 7'b1000000) begin
            errors++; $display("FAIL rst_ptr_m0 got %b expected 1000000", status());
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0010000 || bus.m0_rdata !== 32'hA5A5_0001) begin
            errors++; $display("FAIL rst_rd_data got st=%b d0=%h expected 0010000 a5a50001", status(), bus.m0_rdata);
        end
        tick();
        tick();
        checks++;
        if (status() !== 7'b0001000) begin
            errors++; $display("FAIL rst_m1_gnt got %b expected 0001000", status());
        end
        drop(1);
        tick();
        checks++;
        if (status() !== 7'b0000010 || bus.m1_rdata !== 32'h0000_1234) begin
            errors++; $display("FAIL rst_m1_data got st=%b d1=%h expected 0000010 00001234", status(), bus.m1_rdata);
        end
        tick();
        $display("txn reset during ISSUE of write and read");
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 16'd10, 32'h0000_5555);
        tick();
        checks++;
        if (status() !== 7'b1000001) begin
            errors++; $display("FAIL b2b_pre got %b expected 1000001", status());
        end
        drop(0);
        tick();
        drive(1, 1'b1, 16'd9, 32'h9999_0009);
        drive(0, 1'b0, 16'd9, '0);
        tick();
        checks++;
        if (status() !== 7'b0001001 || bus.mem_write_address !== 16'd9) begin
            errors++; $display("FAIL b2b_wr_first got st=%b wa=%h expected 0001001 0009", status(), bus.mem_write_address);
        end
        drop(1);
        tick();
        checks++;
        if (status() !== 7'b0000000) begin
            errors++; $display("FAIL b2b_idle got %b expected 0000000", status());
        end
        tick();
        checks++;
        if (status() !== 7'b1000000 || bus.mem_read_address !== 16'd9) begin
            errors++; $display("FAIL b2b_rd_gnt got st=%b ra=%h expected 1000000 0009", status(), bus.mem_read_address);
        end
        drop(0);
        tick();
        checks++;
        if (status() !== 7'b0010000 || bus.m0_rdata !== 32'h9999_0009 || bus.m1_rdata !== '0) begin
            errors++; $display("FAIL b2b_rd_data got st=%b d0=%h d1=%h expected 0010000 99990009 0",
                               status(), bus.m0_rdata, bus.m1_rdata);
        end
        tick();
        $display("txn m1 write addr 9 then m0 read addr 9");
    endtask

    initial begin
        rst          = 1'b1;
        bus.m0_req   = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req   = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        test_reset();
        test_write_read();
        test_boundary_127();
        test_out_of_range();
        test_round_robin();
        test_reset_in_issue();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
